// File: rtl/axa_pkg.sv
// axa_pkg: definitions shared by the AXA fetch unit.
//   WORD          - datapath width (instruction word and PC)
//   OP_*          - 6-bit major opcode constants
//   NOP_INST      - instruction word delivered when the queue is empty
//   fetch_entry_t - one prefetch queue record {inst, pc, lastpc, fwd}
//   step_pc()     - next sequential PC, forward or reverse, wrapping at 2^WORD
package axa_pkg;

    localparam int WORD = 16;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_LOAD = 6'b010000;
    localparam logic [5:0] OP_STOR = 6'b010001;
    localparam logic [5:0] OP_BRA  = 6'b100000;
    localparam logic [5:0] OP_JMP  = 6'b100001;
    localparam logic [5:0] OP_SYS  = 6'b111000;
    localparam logic [5:0] OP_FAIL = 6'b111001;
    localparam logic [5:0] OP_NOP  = 6'b111010;

    // Opcode in the top six bits, operand field zero-filled.
    localparam logic [WORD-1:0] NOP_INST = {OP_NOP, 10'b00_0000_0000};

    typedef struct packed {
        logic [WORD-1:0] inst;
        logic [WORD-1:0] pc;
        logic [WORD-1:0] lastpc;
        logic            fwd;
    } fetch_entry_t;

    // Value held by every unoccupied queue slot, so an empty head reads NOP.
    localparam fetch_entry_t EMPTY_ENTRY = '{
        inst:   NOP_INST,
        pc:     16'h0000,
        lastpc: 16'h0000,
        fwd:    1'b0
    };

    // Sequential PC step; plain modular add/subtract gives FFFF+1=0000 and 0000-1=FFFF.
    function automatic logic [WORD-1:0] step_pc(input logic [WORD-1:0] pc, input logic fwd);
        logic [WORD-1:0] nxt;
        if (fwd) begin
            nxt = pc + 16'h0001;
        end else begin
            nxt = pc - 16'h0001;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/axa_fetch_fifo.sv
// axa_fetch_fifo: shifting prefetch queue whose head is always slot 0.
//   clk, reset      - clock, asynchronous active-low reset
//   push/push_entry - append an entry (ignored when full and not popping)
//   pop             - remove the head (ignored when empty)
//   flush           - discard every entry; takes priority over push
//   head            - slot 0, straight from a register; EMPTY_ENTRY when empty
//   count           - number of occupied slots
module axa_fetch_fifo
    import axa_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t    slot_q  [DEPTH];
    fetch_entry_t    slot_d  [DEPTH];
    fetch_entry_t    shift_s [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   widx_s;
    logic            pop_s;
    logic            push_s;

    // Next-state queue contents: shift on pop, write behind the last live slot on push.
    always_comb begin
        pop_s  = pop && (count_q != CW'(0));
        push_s = push && (pop_s || (count_q < CW'(DEPTH)));
        // Unused slots always refill with EMPTY_ENTRY so the head is NOP when empty.
        for (int i = 0; i < DEPTH; i++) begin
            if (pop_s) begin
                shift_s[i] = (i == DEPTH - 1) ? EMPTY_ENTRY : slot_q[(i + 1) % DEPTH];
            end else begin
                shift_s[i] = slot_q[i];
            end
        end
        widx_s = pop_s ? (count_q - CW'(1)) : count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i] = EMPTY_ENTRY;
            end
            count_d = CW'(0);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i] = (push_s && (widx_s == CW'(i))) ? push_entry : shift_s[i];
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Queue storage and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= EMPTY_ENTRY;
            end
            count_q <= CW'(0);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q <= count_d;
        end
    end

    assign head  = slot_q[0];
    assign count = count_q;

endmodule

// File: rtl/axa_fetch.sv
// axa_fetch: instruction prefetch unit with a DEPTH-entry queue.
//   clk, reset                 - clock, asynchronous active-low reset
//   im_rd, im_addr, im_data    - instruction memory port; data returns one cycle after im_rd
//   fwd                        - 1 steps the PC forward, 0 steps it backward
//   redirect, redirect_target  - taken branch/jump: flush queue, kill the read, reload the PC
//   stop                       - stop issuing reads; in-flight data and the queue still drain
//   out_valid, out_ready       - head handshake towards decode
//   out_inst/out_pc/out_lastpc/out_fwd - head entry fields
//   count                      - occupied queue entries
module axa_fetch
    import axa_pkg::*;
#(
    parameter  int          DEPTH    = 4,
    parameter  logic [15:0] RESET_PC = 16'h0000,
    localparam int          CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          im_rd,
    output logic [15:0]   im_addr,
    input  logic [15:0]   im_data,
    input  logic          fwd,
    input  logic          redirect,
    input  logic [15:0]   redirect_target,
    input  logic          stop,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_inst,
    output logic [15:0]   out_pc,
    output logic [15:0]   out_lastpc,
    output logic          out_fwd,
    output logic [CW-1:0] count
);

    logic [15:0]   pc_q, pc_d;
    logic [15:0]   lastpc_q, lastpc_d;
    logic [15:0]   popped_pc_q, popped_pc_d;
    logic          inflight_q, inflight_d;
    logic [15:0]   req_pc_q, req_pc_d;
    logic [15:0]   req_lastpc_q, req_lastpc_d;
    logic          req_fwd_q, req_fwd_d;
    logic [CW:0]   occ_s;
    logic          issue_s;
    logic          pop_s;
    logic          push_s;
    logic [CW-1:0] count_s;
    fetch_entry_t  head_s;
    fetch_entry_t  push_entry_s;

    // Issue/pop/push decisions. An outstanding read already owns a queue slot.
    always_comb begin
        occ_s   = {1'b0, count_s} + {{CW{1'b0}}, inflight_q};
        issue_s = reset && !stop && !redirect && (occ_s < (CW + 1)'(DEPTH));
        pop_s   = out_valid && out_ready;
        // A redirect kills the read whose data is on im_data this cycle.
        push_s  = inflight_q && !redirect;
        push_entry_s = '{inst: im_data, pc: req_pc_q, lastpc: req_lastpc_q, fwd: req_fwd_q};
    end

    // Next PC, lastpc and the attributes captured with each issued read.
    always_comb begin
        pc_d         = pc_q;
        lastpc_d     = lastpc_q;
        req_pc_d     = req_pc_q;
        req_lastpc_d = req_lastpc_q;
        req_fwd_d    = req_fwd_q;
        inflight_d   = issue_s;
        popped_pc_d  = pop_s ? head_s.pc : popped_pc_q;
        if (redirect) begin
            pc_d = redirect_target;
            // A pop on the same edge is the most recent one, so its pc wins.
            lastpc_d = pop_s ? head_s.pc : popped_pc_q;
        end else if (issue_s) begin
            pc_d = step_pc(pc_q, fwd);
        end else begin
            pc_d = pc_q;
        end
        if (issue_s) begin
            req_pc_d     = pc_q;
            req_lastpc_d = lastpc_q;
            req_fwd_d    = fwd;
        end else begin
            req_pc_d     = req_pc_q;
            req_lastpc_d = req_lastpc_q;
            req_fwd_d    = req_fwd_q;
        end
    end

    // Fetch-control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            lastpc_q     <= 16'h0000;
            popped_pc_q  <= 16'h0000;
            inflight_q   <= 1'b0;
            req_pc_q     <= 16'h0000;
            req_lastpc_q <= 16'h0000;
            req_fwd_q    <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            lastpc_q     <= lastpc_d;
            popped_pc_q  <= popped_pc_d;
            inflight_q   <= inflight_d;
            req_pc_q     <= req_pc_d;
            req_lastpc_q <= req_lastpc_d;
            req_fwd_q    <= req_fwd_d;
        end
    end

    axa_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect),
        .head       (head_s),
        .count      (count_s)
    );

    assign im_rd      = issue_s;
    assign im_addr    = pc_q;
    assign count      = count_s;
    assign out_valid  = (count_s != CW'(0));
    assign out_inst   = head_s.inst;
    assign out_pc     = head_s.pc;
    assign out_lastpc = head_s.lastpc;
    assign out_fwd    = head_s.fwd;

endmodule
